// File: rtl/fir_sequencer.sv
// fir_sequencer: control FSM for the FIR datapath (sample shift, coefficient load, tap MAC sequencing).
// Optional macro FIR_SIGN_ALT_EN: the accumulate step subtracts (R0 - R1) on odd taps.
module fir_sequencer #(
   parameter int NUM_TAPS = 4,
   parameter int REG_W    = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             data_ready_i,
   input  logic             load_coeff_i,
   input  logic             overflow_i,
   output logic [2:0]       op_o,
   output logic [REG_W-1:0] src1_o,
   output logic [REG_W-1:0] src2_o,
   output logic [REG_W-1:0] dest_o,
   output logic             modwait_o,
   output logic             err_o,
   output logic             cnt_up_o
);
   // state   | meaning
   // S_IDLE  | waiting for a sample or coefficient
   // S_COEF  | load one coefficient into its register
   // S_SHIFT | copy sample j-1 into j (j counts down)
   // S_STORE | write the new sample to R2
   // S_ZERO  | clear the accumulator R0
   // S_MUL   | R1 = sample_k * coef_k
   // S_ACC   | R0 = R0 +/- R1, overflow traps
   // S_DONE  | pulse cnt_up
   // S_ERR   | overflow trapped, wait for next sample

   localparam int IW = 3;
   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_COPY = 3'd1;
   localparam logic [2:0] OP_LDS  = 3'd2;
   localparam logic [2:0] OP_LDC  = 3'd3;
   localparam logic [2:0] OP_MUL  = 3'd4;
   localparam logic [2:0] OP_ADD  = 3'd5;
   localparam logic [2:0] OP_SUB  = 3'd6;
   localparam logic [2:0] OP_CLR  = 3'd7;
   localparam logic [REG_W-1:0] SMP_BASE  = REG_W'(2);
   localparam logic [REG_W-1:0] COEF_BASE = REG_W'(2 + NUM_TAPS);
   localparam logic [IW-1:0]    LAST_IDX  = IW'(NUM_TAPS - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_COEF, S_SHIFT, S_STORE, S_ZERO, S_MUL, S_ACC, S_DONE, S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [IW-1:0]     coef_idx_q, coef_idx_d;
   logic              pending_q, pending_d;
   logic [2:0]        op_q, op_d;
   logic [REG_W-1:0]  src1_q, src1_d, src2_q, src2_d, dest_q, dest_d;
   logic              modwait_q, modwait_d, err_q, err_d, cnt_up_q, cnt_up_d;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      coef_idx_d = coef_idx_q;
      pending_d  = pending_q;
      if (data_ready_i && modwait_q) pending_d = 1'b1;
      case (state_q)
         S_IDLE, S_ERR: begin
            if (data_ready_i || pending_q) begin
               state_d   = S_SHIFT;
               idx_d     = LAST_IDX;
               pending_d = 1'b0;
            end else if (load_coeff_i && (state_q == S_IDLE)) begin
               state_d = S_COEF;
            end
         end
         S_COEF: begin
            state_d    = S_IDLE;
            coef_idx_d = (coef_idx_q == LAST_IDX) ? '0 : coef_idx_q + IW'(1);
         end
         S_SHIFT: begin
            if (idx_q == IW'(1)) state_d = S_STORE;
            else                 idx_d   = idx_q - IW'(1);
         end
         S_STORE: state_d = S_ZERO;
         S_ZERO: begin
            state_d = S_MUL;
            idx_d   = '0;
         end
         S_MUL: state_d = S_ACC;
         S_ACC: begin
            if (overflow_i) begin
               state_d = S_ERR;
            end else if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               state_d = S_MUL;
               idx_d   = idx_q + IW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from the next state so the registered outputs track the current state.
   always_comb begin
      op_d      = OP_NOP;
      src1_d    = '0;
      src2_d    = '0;
      dest_d    = '0;
      modwait_d = 1'b1;
      err_d     = 1'b0;
      cnt_up_d  = 1'b0;
      case (state_d)
         S_IDLE: modwait_d = 1'b0;
         S_ERR: begin
            modwait_d = 1'b0;
            err_d     = 1'b1;
         end
         S_COEF: begin
            op_d   = OP_LDC;
            dest_d = COEF_BASE + REG_W'(coef_idx_q);
         end
         S_SHIFT: begin
            op_d   = OP_COPY;
            src1_d = REG_W'(idx_d) + REG_W'(1);
            dest_d = SMP_BASE + REG_W'(idx_d);
         end
         S_STORE: begin
            op_d   = OP_LDS;
            dest_d = SMP_BASE;
         end
         S_ZERO: op_d = OP_CLR;
         S_MUL: begin
            op_d   = OP_MUL;
            src1_d = SMP_BASE + REG_W'(idx_d);
            src2_d = COEF_BASE + REG_W'(idx_d);
            dest_d = REG_W'(1);
         end
         S_ACC: begin
`ifdef FIR_SIGN_ALT_EN
            op_d   = idx_d[0] ? OP_SUB : OP_ADD;
`else
            op_d   = OP_ADD;
`endif
            src2_d = REG_W'(1);
         end
         S_DONE:  cnt_up_d = 1'b1;
         default: modwait_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         coef_idx_q <= '0;
         pending_q  <= 1'b0;
         op_q       <= OP_NOP;
         src1_q     <= '0;
         src2_q     <= '0;
         dest_q     <= '0;
         modwait_q  <= 1'b0;
         err_q      <= 1'b0;
         cnt_up_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         coef_idx_q <= coef_idx_d;
         pending_q  <= pending_d;
         op_q       <= op_d;
         src1_q     <= src1_d;
         src2_q     <= src2_d;
         dest_q     <= dest_d;
         modwait_q  <= modwait_d;
         err_q      <= err_d;
         cnt_up_q   <= cnt_up_d;
      end
   end

   assign op_o      = op_q;
   assign src1_o    = src1_q;
   assign src2_o    = src2_q;
   assign dest_o    = dest_q;
   assign modwait_o = modwait_q;
   assign err_o     = err_q;
   assign cnt_up_o  = cnt_up_q;

endmodule

// File: tb/tb_fir_sequencer.sv
// Bench for fir_sequencer: directed steps plus random traffic, checked every cycle against a
// program-list reference model (each accepted sample expands into its full op listing).
module tb_fir_sequencer;
   localparam int N  = 4;
   localparam int RW = 4;

   logic          clk_i = 1'b0;
   logic          rst_i, data_ready_i, load_coeff_i, overflow_i;
   logic [2:0]    op_o;
   logic [RW-1:0] src1_o, src2_o, dest_o;
   logic          modwait_o, err_o, cnt_up_o;

   fir_sequencer #(.NUM_TAPS(N), .REG_W(RW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .data_ready_i(data_ready_i),
      .load_coeff_i(load_coeff_i), .overflow_i(overflow_i),
      .op_o(op_o), .src1_o(src1_o), .src2_o(src2_o), .dest_o(dest_o),
      .modwait_o(modwait_o), .err_o(err_o), .cnt_up_o(cnt_up_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [2:0]    op;
      logic [RW-1:0] s1;
      logic [RW-1:0] s2;
      logic [RW-1:0] d;
      logic          mw;
      logic          er;
      logic          cu;
   } word_t;

   word_t cur;
   word_t prog[$];
   logic  pend;
   int    cidx;
   int    total = 0;
   int    bad   = 0;
   int    ncnt, cyc_no, first_cu, last_cu, mwc;

   function automatic word_t w(input int op, input int s1, input int s2, input int d,
                               input bit mw, input bit er, input bit cu);
      word_t r;
      r.op = 3'(op); r.s1 = RW'(s1); r.s2 = RW'(s2); r.d = RW'(d);
      r.mw = mw; r.er = er; r.cu = cu;
      return r;
   endfunction

   function automatic int acc_op(input int k);
`ifdef FIR_SIGN_ALT_EN
      return (k % 2 == 1) ? 6 : 5;
`else
      return 5;
`endif
   endfunction

   task automatic load_sample();
      for (int j = N - 1; j >= 1; j--) prog.push_back(w(1, 1 + j, 0, 2 + j, 1, 0, 0));
      prog.push_back(w(2, 0, 0, 2, 1, 0, 0));
      prog.push_back(w(7, 0, 0, 0, 1, 0, 0));
      for (int k = 0; k < N; k++) begin
         prog.push_back(w(4, 2 + k, 2 + N + k, 1, 1, 0, 0));
         prog.push_back(w(acc_op(k), 0, 1, 0, 1, 0, 0));
      end
      prog.push_back(w(0, 0, 0, 0, 1, 0, 1));
   endtask

   task automatic model_edge(input logic dr, input logic lc, input logic ov, input logic r);
      if (r) begin
         prog.delete(); pend = 1'b0; cidx = 0; cur = '0;
      end else if (!cur.mw) begin
         if (dr || pend) begin
            load_sample(); pend = 1'b0; cur = prog.pop_front();
         end else if (lc && !cur.er) begin
            cur  = w(3, 0, 0, 2 + N + cidx, 1, 0, 0);
            cidx = (cidx + 1) % N;
         end
      end else begin
         if (dr) pend = 1'b1;
         if ((cur.op == 3'd5 || cur.op == 3'd6) && ov) begin
            prog.delete(); cur = w(0, 0, 0, 0, 0, 1, 0);
         end else if (prog.size() > 0) cur = prog.pop_front();
         else cur = '0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc_no);
      end
   endtask

   task automatic step(input logic dr, input logic lc, input logic ov, input logic r);
      data_ready_i = dr; load_coeff_i = lc; overflow_i = ov; rst_i = r;
      @(posedge clk_i);
      model_edge(dr, lc, ov, r);
      #1;
      cyc_no++;
      chk("op", op_o, cur.op);
      chk("src1", src1_o, cur.s1);
      chk("src2", src2_o, cur.s2);
      chk("dest", dest_o, cur.d);
      chk("modwait", modwait_o, cur.mw);
      chk("err", err_o, cur.er);
      chk("cnt_up", cnt_up_o, cur.cu);
      if (modwait_o === 1'b1) mwc++;
      if (cnt_up_o === 1'b1) begin
         ncnt++;
         if (first_cu < 0) first_cu = cyc_no;
         last_cu = cyc_no;
      end
   endtask

   task automatic win_reset();
      cyc_no = 0; ncnt = 0; mwc = 0; first_cu = -1; last_cu = -1;
   endtask

   initial begin
      data_ready_i = 0; load_coeff_i = 0; overflow_i = 0; rst_i = 1;
      cur = '0; pend = 0; cidx = 0;
      win_reset();

      step(0, 0, 0, 1); step(0, 0, 0, 1);
      chk("reset_op", op_o, 0);
      chk("reset_modwait", modwait_o, 0);
      chk("reset_err", err_o, 0);

      // coefficient loads, fifth wraps to the first coefficient register
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 0);
         chk("coef_dest", dest_o, 2 + N + (i % N));
         chk("coef_op", op_o, 3);
         step(0, 0, 0, 0);
         chk("coef_mw_low", modwait_o, 0);
      end

      // single sample: latency and busy window
      win_reset();
      step(1, 0, 0, 0);
      for (int i = 0; i < 15; i++) step(0, 0, 0, 0);
      chk("single_latency", last_cu, 3 * N + 2);
      chk("single_mw_cycles", mwc, 3 * N + 2);
      chk("single_cnt", ncnt, 1);

      // reset in MUL_1 aborts without cnt_up
      win_reset();
      step(1, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
      chk("mul1_op", op_o, 4);
      chk("mul1_src1", src1_o, 3);
      step(0, 0, 0, 1); step(0, 0, 0, 1);
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      chk("abort_op", op_o, 0);
      chk("abort_mw", modwait_o, 0);
      chk("abort_cnt", ncnt, 0);
      win_reset();
      step(1, 0, 0, 0);
      for (int i = 0; i < 15; i++) step(0, 0, 0, 0);
      chk("post_reset_latency", last_cu, 3 * N + 2);

      // pending: pulse at cycle 5 queued, pulse at cycle 6 dropped
      win_reset();
      step(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
      step(1, 0, 0, 0); step(1, 0, 0, 0);
      for (int i = 0; i < 40; i++) step(0, 0, 0, 0);
      chk("pend_cnt", ncnt, 2);
      chk("pend_first", first_cu, 3 * N + 2);
      chk("pend_second", last_cu, 2 * (3 * N + 2) + 1);

      // overflow in ACC_2 traps, next sample clears err
      win_reset();
      step(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
      chk("acc2_op", op_o, acc_op(2));
      step(0, 0, 1, 0);
      chk("ovf_err", err_o, 1);
      chk("ovf_mw", modwait_o, 0);
      step(0, 0, 1, 0); step(0, 1, 0, 0); step(0, 0, 0, 0);
      chk("ovf_hold_err", err_o, 1);
      chk("ovf_cnt", ncnt, 0);
      step(1, 0, 0, 0);
      chk("recover_err", err_o, 0);
      chk("recover_op", op_o, 1);
      for (int i = 0; i < 15; i++) step(0, 0, 0, 0);
      chk("recover_cnt", ncnt, 1);

      // random traffic
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 14) == 0, $urandom_range(0, 299) == 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
